mul_recombine: RTL and testbench

//  Sequential signed shift-add multiplier-accumulator: computes Quotient*Divisor + Remain.

---
 rtl/ode_arith_pkg.sv | 24 ++
 rtl/sign_mag.sv | 18 +
 rtl/mul_recombine.sv | 120 ++++++++++++
 tb/tb_mul_recombine.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ode_arith_pkg.sv
// Shared arithmetic definitions for the ODE-solver datapath (divider and recombiner).
package ode_arith_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Sign-extend a DEF_WIDTH value to the 2*DEF_WIDTH+1 sum width.
    function automatic logic [2*DEF_WIDTH:0] sext(input logic [DEF_WIDTH-1:0] x);
        return {{(DEF_WIDTH+1){x[DEF_WIDTH-1]}}, x};
    endfunction

    // Magnitude with one extra bit so that |-2^(W-1)| is representable.
    function automatic logic [DEF_WIDTH:0] abs_ext(input logic [DEF_WIDTH-1:0] x);
        logic [DEF_WIDTH:0] e;
        e = {x[DEF_WIDTH-1], x};
        return x[DEF_WIDTH-1] ? -e : e;
    endfunction

endpackage

// File: rtl/sign_mag.sv
// Combinational two's complement to sign-magnitude converter (WIDTH+1-bit magnitude).
module sign_mag #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    output logic             sign_c,
    output logic [WIDTH:0]   mag_c
);

    logic [WIDTH:0] ext;

    always_comb begin
        ext    = {value[WIDTH-1], value};
        sign_c = value[WIDTH-1];
        mag_c  = sign_c ? -ext : ext;
    end

endmodule

// File: rtl/mul_recombine.sv
// Sequential signed shift-add multiply-accumulate: Product = Quotient*Divisor,
// Dividend = Product + Remain (low WIDTH bits) with a signed overflow flag.
module mul_recombine
    import ode_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Quotient,
    input  logic [WIDTH-1:0]     Divisor,
    input  logic [WIDTH-1:0]     Remain,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Product,
    output logic [WIDTH-1:0]     Dividend,
    output logic                 ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = 2 * WIDTH + 1;

    state_e              state, state_n;
    logic [CW-1:0]       count, count_n;
    logic [SW-1:0]       sr, sr_n;
    logic [WIDTH:0]      mcand, mcand_n;
    logic                neg, neg_n;
    logic [WIDTH-1:0]    rem, rem_n;
    logic                busy_n, done_n, ovf_n;
    logic [2*WIDTH-1:0]  product_n;
    logic [WIDTH-1:0]    dividend_n;

    logic                q_sign, d_sign;
    logic [WIDTH:0]      q_mag, d_mag;
    logic [WIDTH:0]      acc_c;
    logic [2*WIDTH-1:0]  prod_c;
    logic [SW-1:0]       sum_c;
    logic                ovf_c;

    sign_mag #(.WIDTH(WIDTH)) u_q_sm (.value(Quotient), .sign_c(q_sign), .mag_c(q_mag));
    sign_mag #(.WIDTH(WIDTH)) u_d_sm (.value(Divisor),  .sign_c(d_sign), .mag_c(d_mag));

    // Datapath: conditional add into the upper field, signed result and representability.
    always_comb begin
        acc_c  = sr[0] ? (sr[SW-1:WIDTH] + mcand) : sr[SW-1:WIDTH];
        prod_c = neg ? -sr[2*WIDTH-1:0] : sr[2*WIDTH-1:0];
        sum_c  = {prod_c[2*WIDTH-1], prod_c} + {{(WIDTH+1){rem[WIDTH-1]}}, rem};
        ovf_c  = !((&sum_c[SW-1:WIDTH-1]) | ~(|sum_c[SW-1:WIDTH-1]));
    end

    // Next-state and next-register logic.
    always_comb begin
        state_n    = state;
        count_n    = count;
        sr_n       = sr;
        mcand_n    = mcand;
        neg_n      = neg;
        rem_n      = rem;
        product_n  = Product;
        dividend_n = Dividend;
        ovf_n      = ovf;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    count_n = '0;
                    sr_n    = {WIDTH'(0), q_mag};
                    mcand_n = d_mag;
                    neg_n   = q_sign ^ d_sign;
                    rem_n   = Remain;
                end
            end
            ST_RUN: begin
                if (count == CW'(WIDTH)) begin
                    state_n    = ST_DONE;
                    product_n  = prod_c;
                    dividend_n = sum_c[WIDTH-1:0];
                    ovf_n      = ovf_c;
                end else begin
                    sr_n    = {acc_c, sr[WIDTH-1:0]} >> 1;
                    count_n = count + CW'(1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            sr       <= '0;
            mcand    <= '0;
            neg      <= 1'b0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Product  <= '0;
            Dividend <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            sr       <= sr_n;
            mcand    <= mcand_n;
            neg      <= neg_n;
            rem      <= rem_n;
            busy     <= busy_n;
            done     <= done_n;
            Product  <= product_n;
            Dividend <= dividend_n;
            ovf      <= ovf_n;
        end
    end

endmodule

// File: tb/tb_mul_recombine.sv
// Directed and scoreboard-driven bench for mul_recombine at WIDTH=16.
module tb_mul_recombine;

    localparam int unsigned W = 16;
    localparam int LAT = W + 1;

    typedef struct packed {
        logic [31:0] prod;
        logic [15:0] dvd;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] Quotient, Divisor, Remain;
    logic        busy, done, ovf;
    logic [31:0] Product;
    logic [15:0] Dividend;

    int   checks   = 0;
    int   failures = 0;
    int   op_id    = 0;
    exp_t sb[$];

    mul_recombine #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Quotient(Quotient), .Divisor(Divisor), .Remain(Remain),
        .busy(busy), .done(done), .Product(Product),
        .Dividend(Dividend), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r);
        longint p, s;
        exp_t   e;
        p      = longint'($signed(q)) * longint'($signed(d));
        s      = p + longint'($signed(r));
        e.prod = p[31:0];
        e.dvd  = s[15:0];
        e.ovf  = (s < -32768) || (s > 32767);
        return e;
    endfunction

    // One operation; inject>0 pulses start with other operands in that RUN cycle,
    // abort_at>0 asserts reset after that RUN edge instead of waiting for done.
    task automatic do_op(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r,
                         input int inject, input int abort_at);
        int   lat;
        exp_t e;
        op_id++;
        @(negedge clk);
        start = 1'b1; Quotient = q; Divisor = d; Remain = r;
        @(posedge clk); #1;
        start = 1'b0;
        Quotient = 16'($urandom); Divisor = 16'($urandom); Remain = 16'($urandom);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == inject) begin
                start = 1'b1; Quotient = 16'h0123; Divisor = 16'h0456; Remain = 16'h0007;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check($sformatf("op%0d_abort_outputs", op_id),
                      {busy, done, ovf, Product, Dividend}, 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        check($sformatf("op%0d_latency", op_id), 64'(lat), 64'(LAT));
        if (lat != 0) begin
            if (sb.size() == 0) begin
                check($sformatf("op%0d_sb_nonempty", op_id), 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("op%0d_product", op_id), 64'(Product), 64'(e.prod));
                check($sformatf("op%0d_dividend", op_id), 64'(Dividend), 64'(e.dvd));
                check($sformatf("op%0d_ovf", op_id), 64'(ovf), 64'(e.ovf));
            end
        end
        @(posedge clk); #1;
        check($sformatf("op%0d_idle_after", op_id), {62'd0, busy, done}, 64'd0);
    endtask

    task automatic watch_no_done(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    int rt[10][4] = '{
        '{100, 7, 14, 2},          '{-100, 7, -14, -2},
        '{100, -7, -14, 2},        '{-100, -7, 14, -2},
        '{32767, 2, 16383, 1},     '{-32768, 3, -10922, -2},
        '{-32768, -32768, 1, 0},   '{5, 100, 0, 5},
        '{-1, 1, -1, 0},           '{12345, -123, -100, 45}
    };

    initial begin
        exp_t e;
        logic [15:0] rq, rd, rr;
        rst_n = 1'b1; start = 1'b0;
        Quotient = '0; Divisor = '0; Remain = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        check("reset_product", 64'(Product), 64'd0);
        check("reset_dividend_ovf", {47'd0, Dividend, ovf}, 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        sb.push_back('{32'hFFFF_FFEB, 16'hFFED, 1'b0});
        do_op(16'd7, 16'hFFFD, 16'd2, 0, 0);
        sb.push_back('{32'h0000_8000, 16'h8000, 1'b1});
        do_op(16'h8000, 16'hFFFF, 16'd0, 0, 0);
        sb.push_back('{32'hFFFF_8000, 16'h8000, 1'b0});
        do_op(16'h8000, 16'd1, 16'd0, 0, 0);
        sb.push_back('{32'h0000_0000, 16'hFFFB, 1'b0});
        do_op(16'd0, 16'd1234, 16'hFFFB, 0, 0);
        sb.push_back('{32'h0000_0000, 16'h0003, 1'b0});
        do_op(16'd0, 16'hFFF9, 16'd3, 0, 0);
        sb.push_back('{32'h3FFF_0001, 16'h8000, 1'b1});
        do_op(16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0);

        // Round trip of divider vectors (a, b, q, r): q*b + r must rebuild a.
        for (int i = 0; i < 10; i++) begin
            e      = model(16'(rt[i][2]), 16'(rt[i][1]), 16'(rt[i][3]));
            e.dvd  = 16'(rt[i][0]);
            e.ovf  = 1'b0;
            sb.push_back(e);
            do_op(16'(rt[i][2]), 16'(rt[i][1]), 16'(rt[i][3]), 0, 0);
        end

        for (int i = 0; i < 6; i++) begin
            rq = 16'($urandom); rd = 16'($urandom); rr = 16'($urandom);
            sb.push_back(model(rq, rd, rr));
            do_op(rq, rd, rr, 0, 0);
        end

        // start during RUN must not disturb the operation in flight
        sb.push_back('{32'hFFFF_FD44, 16'hFD49, 1'b0});
        do_op(16'd100, 16'hFFF9, 16'd5, 5, 0);
        watch_no_done(30, "no_second_done");

        // reset in RUN cycle 8 aborts without a done pulse
        do_op(16'd1000, 16'd1000, 16'd0, 0, 8);
        watch_no_done(25, "no_done_after_abort");

        sb.push_back('{32'h0000_4E20, 16'h4E20, 1'b0});
        do_op(16'd100, 16'd200, 16'd0, 0, 0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
